// File: rtl/dc_mean_sub_pkg.sv
// Shared constants for the DC-removal stage and the saturating subtractor
// that later feature stages reuse.
package dc_mean_sub_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_LOG2_WIN = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [DEF_DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/dc_mean_sub_sat_sub16.sv
// Combinational a - b at one extra bit of headroom, clamped back to the
// signed sample range.
module sat_sub16
    import dc_mean_sub_pkg::*;
(
    input  logic signed [DEF_DATA_W-1:0] i_a,
    input  logic signed [DEF_DATA_W-1:0] i_b,
    output logic signed [DEF_DATA_W-1:0] o_y
);

    logic signed [DEF_DATA_W:0] w_diff;

    assign w_diff = {i_a[DEF_DATA_W-1], i_a} - {i_b[DEF_DATA_W-1], i_b};

    // The top two bits disagree exactly when the result leaves the DATA_W range.
    always_comb begin
        o_y = w_diff[DEF_DATA_W-1:0];
        if (w_diff[DEF_DATA_W] != w_diff[DEF_DATA_W-1]) begin
            o_y = w_diff[DEF_DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/dc_mean_sub.sv
// Running-mean DC removal: subtracts the mean of the last 2^LOG2_WIN samples
// (current one included) and emits a saturated sample with a one-cycle strobe.
module dc_mean_sub
    import dc_mean_sub_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOG2_WIN = DEF_LOG2_WIN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic signed [DATA_W-1:0] audio_out,
    output logic                     out_valid,
    output logic                     primed,
    output logic                     overrun
);

    localparam int WIN   = 1 << LOG2_WIN;
    localparam int ACC_W = DATA_W + LOG2_WIN;

    logic        [1:0]          r_state;
    logic signed [DATA_W-1:0]   r_buf [WIN];
    logic        [LOG2_WIN-1:0] r_wrPtr;
    logic        [LOG2_WIN:0]   r_fill;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [DATA_W-1:0]   r_x;
    logic signed [DATA_W-1:0]   r_old;

    logic signed [ACC_W-1:0]    w_xExt;
    logic signed [ACC_W-1:0]    w_oldExt;
    logic signed [DATA_W-1:0]   w_mean;
    logic signed [DATA_W-1:0]   w_satOut;

    assign w_xExt   = {{LOG2_WIN{r_x[DATA_W-1]}}, r_x};
    assign w_oldExt = {{LOG2_WIN{r_old[DATA_W-1]}}, r_old};

    // Taking the upper DATA_W bits is the floor division by the window length.
    assign w_mean   = r_acc[ACC_W-1:LOG2_WIN];
    assign primed   = r_fill[LOG2_WIN];

    sat_sub16 u_satSub (
        .i_a (r_x),
        .i_b (w_mean),
        .o_y (w_satOut)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_wrPtr   <= '0;
            r_fill    <= '0;
            r_acc     <= '0;
            r_x       <= '0;
            r_old     <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < WIN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        r_x     <= sample_in;
                        r_old   <= r_buf[r_wrPtr];
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc          <= r_acc + w_xExt - w_oldExt;
                    r_buf[r_wrPtr] <= r_x;
                    r_wrPtr        <= r_wrPtr + LOG2_WIN'(1);
                    if (!r_fill[LOG2_WIN]) begin
                        r_fill <= r_fill + (LOG2_WIN + 1)'(1);
                    end
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    audio_out <= w_satOut;
                    out_valid <= 1'b1;
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dc_mean_sub.sv
// Directed bench for dc_mean_sub: reset, warm-up mean, wrap, saturation,
// overrun and mid-operation reset, each against hand-computed values.
module tb_dc_mean_sub;

    logic               clk;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic signed [15:0] audio_out;
    logic               out_valid;
    logic               primed;
    logic               overrun;

    int checks;
    int errors;

    dc_mean_sub dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .primed       (primed),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one strobe from a negedge and returns at the negedge where out_valid is seen.
    task automatic sendSample(input logic signed [15:0] v, output logic signed [15:0] got,
                              output int lat, output logic firstOv);
        sample_in    = v;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        firstOv = out_valid;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = audio_out;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (audio_out !== 16'sd0) begin
            errors++; $display("[TB] FAIL reset_audio_out: got %0d expected 0", audio_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (primed !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_primed: got %b expected 0", primed);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_first_samples();
        logic signed [15:0] got;
        int lat;
        logic firstOv;
        applyReset();
        sendSample(16'sd1000, got, lat, firstOv);
        checks++;
        if (lat !== 3) begin
            errors++; $display("[TB] FAIL first_latency: got %0d expected 3", lat);
        end
        checks++;
        if (got !== 16'sd985) begin
            errors++; $display("[TB] FAIL first_sample: got %0d expected 985", got);
        end
        sendSample(16'sd1000, got, lat, firstOv);
        checks++;
        if (firstOv !== 1'b0) begin
            errors++; $display("[TB] FAIL out_valid_double: got %b expected 0", firstOv);
        end
        checks++;
        if (got !== 16'sd969) begin
            errors++; $display("[TB] FAIL second_sample: got %0d expected 969", got);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] got;
        int lat;
        logic firstOv;
        int expv;
        applyReset();
        for (int k = 1; k <= 65; k++) begin
            sendSample(16'sd1000, got, lat, firstOv);
            expv = (k <= 64) ? (1000 - (1000 * k) / 64) : 0;
            checks++;
            if (got !== 16'(expv) || lat !== 3) begin
                errors++;
                $display("[TB] FAIL b2b_out[%0d]: got %0d lat %0d expected %0d lat 3", k, got, lat, expv);
            end
            checks++;
            if (primed !== (k >= 64)) begin
                errors++; $display("[TB] FAIL b2b_primed[%0d]: got %b expected %b", k, primed, (k >= 64));
            end
            if (k > 1) begin
                checks++;
                if (firstOv !== 1'b0) begin
                    errors++; $display("[TB] FAIL b2b_double_valid[%0d]: got %b expected 0", k, firstOv);
                end
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_negative_floor();
        logic signed [15:0] got;
        int lat;
        logic firstOv;
        applyReset();
        sendSample(-16'sd1, got, lat, firstOv);
        checks++;
        if (got !== 16'sd0) begin
            errors++; $display("[TB] FAIL neg_floor: got %0d expected 0", got);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] got;
        int lat;
        logic firstOv;
        int expv;
        applyReset();
        for (int k = 1; k <= 64; k++) begin
            sendSample(16'sh8000, got, lat, firstOv);
            expv = -32768 + 512 * k;
            checks++;
            if (got !== 16'(expv)) begin
                errors++; $display("[TB] FAIL min_fill[%0d]: got %0d expected %0d", k, got, expv);
            end
        end
        sendSample(16'sh7FFF, got, lat, firstOv);
        checks++;
        if (got !== 16'sh7FFF) begin
            errors++; $display("[TB] FAIL sat_pos: got %0d expected 32767", got);
        end
        for (int k = 1; k <= 64; k++) begin
            sendSample(16'sh7FFF, got, lat, firstOv);
        end
        checks++;
        if (got !== 16'sd0) begin
            errors++; $display("[TB] FAIL max_fill_last: got %0d expected 0", got);
        end
        sendSample(16'sh8000, got, lat, firstOv);
        checks++;
        if (got !== 16'sh8000) begin
            errors++; $display("[TB] FAIL sat_neg: got %0d expected -32768", got);
        end
    endtask

    task automatic test_overrun();
        logic signed [15:0] got;
        logic signed [15:0] captured;
        int lat;
        logic firstOv;
        int pulses;
        applyReset();
        sample_in    = 16'sd1000;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_in = 16'sd5000;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        pulses   = 0;
        captured = '0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                captured = audio_out;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("[TB] FAIL overrun_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (captured !== 16'sd985) begin
            errors++; $display("[TB] FAIL overrun_value: got %0d expected 985", captured);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", overrun);
        end
        sendSample(16'sd1000, got, lat, firstOv);
        checks++;
        if (got !== 16'sd969) begin
            errors++; $display("[TB] FAIL overrun_acc: got %0d expected 969", got);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid_acc();
        logic signed [15:0] got;
        int lat;
        logic firstOv;
        int pulses;
        applyReset();
        sendSample(16'sd1000, got, lat, firstOv);
        sendSample(16'sd1000, got, lat, firstOv);
        sample_in    = 16'sd2000;
        sample_valid = 1'b1;
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (audio_out !== 16'sd0 || out_valid !== 1'b0 || primed !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got out=%0d v=%b p=%b o=%b expected all 0",
                     audio_out, out_valid, primed, overrun);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("[TB] FAIL midreset_no_valid: got %0d expected 0", pulses);
        end
        sendSample(16'sd1000, got, lat, firstOv);
        checks++;
        if (got !== 16'sd985) begin
            errors++; $display("[TB] FAIL midreset_after: got %0d expected 985", got);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        test_reset();
        test_first_samples();
        test_back_to_back();
        test_negative_floor();
        test_saturation();
        test_overrun();
        test_reset_mid_acc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
